// File: rtl/sn76489_pkg.sv
// Shared definitions for the SN76489 attenuator family.
// Contents:
//   att_t      - 4-bit attenuation code (0 loudest, 15 off)
//   ATT_OFF    - code that silences a channel
//   VOL_TABLE  - 8-bit base amplitude for each attenuation code
//   ramp_dir_e - per-channel ramp direction
package sn76489_pkg;

  typedef logic [3:0] att_t;

  localparam att_t ATT_OFF = 4'd15;

  // Index 0 is the rightmost element: code 0 -> 31, code 15 -> 0.
  localparam logic [15:0][7:0] VOL_TABLE = {
    8'd0,  8'd1,  8'd2,  8'd2,  8'd2,  8'd3,  8'd4,  8'd5,
    8'd6,  8'd8,  8'd10, 8'd12, 8'd16, 8'd20, 8'd25, 8'd31
  };

  typedef enum logic [1:0] {
    RAMP_IDLE = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_dir_e;

endpackage

// File: rtl/sn76489_multi_attenuator_chan.sv
// One attenuator channel: target/live attenuation registers, optional ramp
// stepping, and the registered gated amplitude.
// Macro: SN76489_ATT_RAMP_EN enables ramp stepping of the live attenuation.
// Ports:
//   clock_i, reset_i - clock and synchronous active-high reset
//   step_i           - shared ramp step pulse (unused without ramp engine)
//   wr_i, wr_att_i   - decoded write strobe and attenuation code
//   factor_i         - tone/noise bit for this channel
//   product_o        - registered amplitude
//   ramping_o        - live attenuation differs from target
module sn76489_att_chan
  import sn76489_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             step_i,
  input  logic             wr_i,
  input  att_t             wr_att_i,
  input  logic             factor_i,
  output logic [OUT_W-1:0] product_o,
  output logic             ramping_o
);

  att_t target_q;
  att_t cur_q;
  logic [OUT_W-1:0] amp;

  assign amp = OUT_W'(VOL_TABLE[cur_q]) << (OUT_W - 8);

`ifdef SN76489_ATT_RAMP_EN
  ramp_dir_e dir;

  always_comb begin
    dir = RAMP_IDLE;
    if (cur_q < target_q)      dir = RAMP_UP;
    else if (cur_q > target_q) dir = RAMP_DOWN;
  end

  // The step uses the direction toward the old target; a coincident write
  // only changes the target, so direction is re-evaluated next cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      target_q  <= ATT_OFF;
      cur_q     <= ATT_OFF;
      product_o <= '0;
    end else begin
      if (wr_i) target_q <= wr_att_i;
      if (step_i) begin
        case (dir)
          RAMP_UP:   cur_q <= cur_q + 4'd1;
          RAMP_DOWN: cur_q <= cur_q - 4'd1;
          default:   ;
        endcase
      end
      product_o <= factor_i ? amp : '0;
    end
  end

  assign ramping_o = (dir != RAMP_IDLE);
`else
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      target_q  <= ATT_OFF;
      cur_q     <= ATT_OFF;
      product_o <= '0;
    end else begin
      if (wr_i) begin
        target_q <= wr_att_i;
        cur_q    <= wr_att_i;
      end
      product_o <= factor_i ? amp : '0;
    end
  end

  logic step_unused;
  assign step_unused = step_i ^ (|target_q);
  assign ramping_o   = 1'b0;
`endif

endmodule

// File: rtl/sn76489_multi_attenuator.sv
// Multi-channel SN76489 attenuator: per-channel programmable attenuation
// gating tone/noise bits into registered amplitudes, plus a registered mix.
// Macro: SN76489_ATT_RAMP_EN adds a shared prescaler and per-channel ramping
// of live attenuation toward the written target, one code per step.
// Ports:
//   clock_i, reset_i     - clock and synchronous active-high reset
//   clock_en_i           - chip clock enable (drives ramp prescaler only)
//   wr_i, wr_ch_i, wr_att_i - attenuation write; out-of-range channel ignored
//   factor_i             - per-channel tone/noise bits
//   product_o            - per-channel amplitudes, channel c at [c*OUT_W +: OUT_W]
//   mix_o                - registered sum of all products
//   ramping_o            - per-channel live-vs-target mismatch
module sn76489_multi_attenuator
  import sn76489_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int OUT_W    = 8,
  parameter int RAMP_DIV = 16
) (
  input  logic                                       clock_i,
  input  logic                                       reset_i,
  input  logic                                       clock_en_i,
  input  logic                                       wr_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch_i,
  input  logic [3:0]                                 wr_att_i,
  input  logic [NUM_CH-1:0]                          factor_i,
  output logic [NUM_CH*OUT_W-1:0]                    product_o,
  output logic [OUT_W+$clog2(NUM_CH)-1:0]            mix_o,
  output logic [NUM_CH-1:0]                          ramping_o
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MW  = OUT_W + $clog2(NUM_CH);

  logic wr_valid;
  logic step;

  assign wr_valid = wr_i && ({1'b0, wr_ch_i} < (CHW+1)'(NUM_CH));

`ifdef SN76489_ATT_RAMP_EN
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PW-1:0] presc_q;

  assign step = clock_en_i && (presc_q == PW'(RAMP_DIV - 1));

  always_ff @(posedge clock_i) begin
    if (reset_i)         presc_q <= '0;
    else if (clock_en_i) presc_q <= step ? '0 : presc_q + PW'(1);
  end
`else
  logic ramp_unused;
  assign ramp_unused = clock_en_i ^ (RAMP_DIV > 0);
  assign step        = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    sn76489_att_chan #(
      .OUT_W (OUT_W)
    ) u_chan (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .step_i    (step),
      .wr_i      (wr_valid && (wr_ch_i == CHW'(c))),
      .wr_att_i  (wr_att_i),
      .factor_i  (factor_i[c]),
      .product_o (product_o[c*OUT_W +: OUT_W]),
      .ramping_o (ramping_o[c])
    );
  end

  logic [MW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sum = sum + MW'(product_o[c*OUT_W +: OUT_W]);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) mix_o <= '0;
    else         mix_o <= sum;
  end

endmodule
